regs_wb: RTL and testbench
==========================

// Module: regs_wb
// PURPOSE
// - Write-back controller: the only driver of the register file write port (wen_REGS/aind_REGS/din_REGS).
// - Merges two result streams into the single write port: ALU results and load responses from memory.
// - Load responses are buffered in a small queue.
// - Keeps a pending-load scoreboard so decode can stall on RAW/WAW hazards; the register file has no bypass.
// PARAMETERS
// - XLEN      64  data width of results and register file
// - NREG      32  number of architectural registers
// - AW        5   register index width, log2(NREG)
// - LQ_DEPTH  2   load-response queue depth (power of 2, >=2)
// PORTS
// - clk             in   1     clock, all state on rising edge
// - rst_n           in   1     reset, asynchronous assert, active-low
// - alu_valid_WB    in   1     ALU result valid
// - alu_ready_WB    out  1     ALU result accepted when valid&ready
// - alu_rd_WB       in   AW    ALU destination register
// - alu_data_WB     in   XLEN  ALU result
// - ld_issue_WB     in   1     decode issued a load this cycle
// - ld_issue_rd_WB  in   AW    destination of issued load
// - ld_valid_WB     in   1     load response valid
// - ld_ready_WB     out  1     load response accepted when valid&ready
// - ld_rd_WB        in   AW    load response destination
// - ld_data_WB      in   XLEN  load data, already extended to XLEN
// - chk_rs1_WB      in   AW    decode source 1 to check
// - chk_rs2_WB      in   AW    decode source 2 to check
// - chk_rd_WB       in   AW    decode destination to check
// - stall_WB        out  1     hazard: any checked register pending
// - pending_WB      out  NREG  scoreboard bit vector
// - err_WB          out  1     sticky: load response to non-pending rd
// - wen_REGS        out  1     register file write enable
// - aind_REGS       out  AW    register file write index
// - din_REGS        out  XLEN  register file write data
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - wen_REGS=0, aind_REGS=0, din_REGS=0; queue empty; pending_WB=0; err_WB=0.
//   - Mid-operation reset drops queued and in-flight writes; no wen pulse after reset release without new input.
// - Output stage: wen_REGS/aind_REGS/din_REGS are registered; wen_REGS is high for exactly one cycle per write.
// - ALU path:
//   - alu_ready_WB = queue empty (loads have priority).
//   - ALU accepted in cycle N -> wen_REGS=1 in cycle N+1.
// - Load path:
//   - ld_ready_WB = !queue_full, computed from registered count only; push-on-full cannot occur.
//   - Accepted response is enqueued at end of cycle N. The queue head is popped to the output stage in cycle N+1 -> wen_REGS=1 in N+2.
//   - One pop per cycle. A push and a pop in the same cycle are both honoured; count is unchanged.
// - rd==0: handshake completes normally, but wen_REGS stays 0 and the output stage holds its value. This applies to both paths.
// - Scoreboard:
//   - Set: ld_issue_WB & ld_issue_rd_WB!=0 sets pending[rd] at the clock edge.
//   - Clear: pending[rd] is cleared at the edge that ends the cycle in which wen_REGS=1 for a load to rd, i.e. once the register file holds the value.
//   - Set and clear of the same rd in the same cycle -> set wins.
//   - pending_WB[0] is hard 0.
//   - stall_WB = pending[chk_rs1] | pending[chk_rs2] | pending[chk_rd]; combinational from registered state.
//   - Decode never issues a load or ALU op to a pending rd; the WAW check via chk_rd guarantees at most one outstanding load per rd.
// - Error: a load response accepted with rd!=0 and pending[rd]=0 sets err_WB. err_WB stays 1 until reset. The write still proceeds.
// - Count arithmetic: pointers are log2(LQ_DEPTH) bits and wrap modulo LQ_DEPTH; count is log2(LQ_DEPTH)+1 bits.
// STRUCTURE
// - Shared package npc_pkg:
//   - XLEN, NREG, AW constants.
//   - wb_entry_t {rd[AW-1:0], data[XLEN-1:0]}.
//   - WB_SRC_ALU/WB_SRC_LD encoding, used for the output-stage source tag that drives scoreboard clear.
// - Sub-module wb_fifo:
//   - Generic synchronous FIFO of wb_entry_t with depth LQ_DEPTH.
//   - Ports: push, pop, full, empty, head; async active-low reset.
// - Top: arbitration mux, output stage register, scoreboard register, error flag.
// TESTING
// - ALU only: alu_valid=1, rd=5, data=0x1234 in cycle 0 -> cycle 1 wen_REGS=1, aind_REGS=5, din_REGS=0x1234; cycle 2 wen_REGS=0.
// - Load RAW:
//   - Stimulus: issue rd=7 in cycle 0; response rd=7, data=0xAB in cycle 3.
//   - Response: stall_WB=1 with chk_rs1=7 from cycle 1 through cycle 5; wen in cycle 5; pending[7]=0 and stall_WB=0 from cycle 6.
// - Priority/full:
//   - Stimulus: two load responses in back-to-back cycles while alu_valid=1 (rd=3).
//   - Response: ld_ready_WB=0 when count=2; alu_ready_WB=0 until the queue drains; writes appear in order ld, ld, alu.
// - x0 and error:
//   - ALU rd=0 -> handshake completes, no wen_REGS.
//   - Load response rd=9 with no issue -> err_WB=1 from the next cycle; it persists.
// - Set/clear same cycle: a load to rd=4 writes back while a new load is issued to rd=4 in the clear cycle -> pending[4] stays 1.
// - Reset mid-flight: assert rst_n=0 with 2 queued loads -> wen_REGS=0, pending_WB=0 immediately; no writes after release.

Source files
------------

// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - shared widths and write-back entry types
package npc_pkg;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  // Output-stage source tag; only load writes retire scoreboard entries
  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LD  = 1'b1
  } wb_src_t;
endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO of write-back entries
module wb_fifo
  import npc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t din,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Storage needs no reset: count gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rptr];
endmodule

// File: rtl/regs_wb.sv
// rtl/regs_wb.sv - register-file write-back arbiter with load scoreboard
module regs_wb
  import npc_pkg::*;
#(
  parameter int LQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid_WB,
  output logic            alu_ready_WB,
  input  logic [AW-1:0]   alu_rd_WB,
  input  logic [XLEN-1:0] alu_data_WB,
  input  logic            ld_issue_WB,
  input  logic [AW-1:0]   ld_issue_rd_WB,
  input  logic            ld_valid_WB,
  output logic            ld_ready_WB,
  input  logic [AW-1:0]   ld_rd_WB,
  input  logic [XLEN-1:0] ld_data_WB,
  input  logic [AW-1:0]   chk_rs1_WB,
  input  logic [AW-1:0]   chk_rs2_WB,
  input  logic [AW-1:0]   chk_rd_WB,
  output logic            stall_WB,
  output logic [NREG-1:0] pending_WB,
  output logic            err_WB,
  output logic            wen_REGS,
  output logic [AW-1:0]   aind_REGS,
  output logic [XLEN-1:0] din_REGS
);
  wb_entry_t       ld_entry;
  wb_entry_t       head;
  logic            lq_full;
  logic            lq_empty;
  logic            push;
  logic            pop;
  logic            alu_fire;
  wb_src_t         src_q;
  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_nxt;
  logic            err_q;

  assign ld_entry     = '{rd: ld_rd_WB, data: ld_data_WB};
  assign ld_ready_WB  = !lq_full;
  assign alu_ready_WB = lq_empty;
  assign push         = ld_valid_WB && ld_ready_WB;
  assign pop          = !lq_empty;
  assign alu_fire     = alu_valid_WB && alu_ready_WB;

  wb_fifo #(.DEPTH(LQ_DEPTH)) u_lq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (ld_entry),
    .pop   (pop),
    .full  (lq_full),
    .empty (lq_empty),
    .head  (head)
  );

  // x0 targets complete their handshake but leave the output stage untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_REGS  <= 1'b0;
      aind_REGS <= '0;
      din_REGS  <= '0;
      src_q     <= WB_SRC_ALU;
    end else begin
      wen_REGS <= 1'b0;
      if (pop) begin
        if (head.rd != '0) begin
          wen_REGS  <= 1'b1;
          aind_REGS <= head.rd;
          din_REGS  <= head.data;
          src_q     <= WB_SRC_LD;
        end
      end else if (alu_fire && alu_rd_WB != '0) begin
        wen_REGS  <= 1'b1;
        aind_REGS <= alu_rd_WB;
        din_REGS  <= alu_data_WB;
        src_q     <= WB_SRC_ALU;
      end
    end
  end

  // Clear applied before set so a same-cycle reissue keeps the bit
  always_comb begin
    pending_nxt = pending_q;
    if (wen_REGS && src_q == WB_SRC_LD) pending_nxt[aind_REGS] = 1'b0;
    if (ld_issue_WB && ld_issue_rd_WB != '0) pending_nxt[ld_issue_rd_WB] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_nxt;
      if (push && ld_rd_WB != '0 && !pending_q[ld_rd_WB]) err_q <= 1'b1;
    end
  end

  assign stall_WB   = pending_q[chk_rs1_WB] | pending_q[chk_rs2_WB] | pending_q[chk_rd_WB];
  assign pending_WB = pending_q;
  assign err_WB     = err_q;
endmodule

// File: tb/tb_regs_wb.sv
// tb/tb_regs_wb.sv - directed and randomized checks of regs_wb
module tb_regs_wb;
  import npc_pkg::*;

  localparam int LQ_DEPTH = 2;

  logic            clk;
  logic            rst_n;
  logic            alu_valid_WB;
  logic            alu_ready_WB;
  logic [AW-1:0]   alu_rd_WB;
  logic [XLEN-1:0] alu_data_WB;
  logic            ld_issue_WB;
  logic [AW-1:0]   ld_issue_rd_WB;
  logic            ld_valid_WB;
  logic            ld_ready_WB;
  logic [AW-1:0]   ld_rd_WB;
  logic [XLEN-1:0] ld_data_WB;
  logic [AW-1:0]   chk_rs1_WB;
  logic [AW-1:0]   chk_rs2_WB;
  logic [AW-1:0]   chk_rd_WB;
  logic            stall_WB;
  logic [NREG-1:0] pending_WB;
  logic            err_WB;
  logic            wen_REGS;
  logic [AW-1:0]   aind_REGS;
  logic [XLEN-1:0] din_REGS;

  int vectors = 0;
  int miscompares = 0;

  regs_wb #(.LQ_DEPTH(LQ_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid_WB(alu_valid_WB), .alu_ready_WB(alu_ready_WB),
    .alu_rd_WB(alu_rd_WB), .alu_data_WB(alu_data_WB),
    .ld_issue_WB(ld_issue_WB), .ld_issue_rd_WB(ld_issue_rd_WB),
    .ld_valid_WB(ld_valid_WB), .ld_ready_WB(ld_ready_WB),
    .ld_rd_WB(ld_rd_WB), .ld_data_WB(ld_data_WB),
    .chk_rs1_WB(chk_rs1_WB), .chk_rs2_WB(chk_rs2_WB), .chk_rd_WB(chk_rd_WB),
    .stall_WB(stall_WB), .pending_WB(pending_WB), .err_WB(err_WB),
    .wen_REGS(wen_REGS), .aind_REGS(aind_REGS), .din_REGS(din_REGS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue of accepted responses, scoreboard bits, last write
  typedef struct {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } resp_t;

  resp_t           m_q[$];
  bit              m_pend[NREG];
  bit              m_err;
  bit              m_wen;
  bit              m_from_ld;
  logic [AW-1:0]   m_aind;
  logic [XLEN-1:0] m_din;

  function automatic void model_reset();
    m_q.delete();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_err = 1'b0; m_wen = 1'b0; m_from_ld = 1'b0; m_aind = '0; m_din = '0;
  endfunction

  function automatic logic [NREG-1:0] model_pend_vec();
    logic [NREG-1:0] v;
    for (int i = 0; i < NREG; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic void model_edge(input bit alu_v, input logic [AW-1:0] a_rd,
                                     input logic [XLEN-1:0] a_d, input bit iss,
                                     input logic [AW-1:0] i_rd, input bit ldv,
                                     input logic [AW-1:0] l_rd, input logic [XLEN-1:0] l_d);
    bit alu_acc = alu_v && (m_q.size() == 0);
    bit ld_acc  = ldv && (m_q.size() < LQ_DEPTH);
    resp_t e;
    if (ld_acc && l_rd != 0 && !m_pend[l_rd]) m_err = 1'b1;
    if (m_wen && m_from_ld) m_pend[m_aind] = 1'b0;
    if (iss && i_rd != 0) m_pend[i_rd] = 1'b1;
    m_wen = 1'b0;
    if (m_q.size() > 0) begin
      e = m_q.pop_front();
      if (e.rd != 0) begin
        m_wen = 1'b1; m_aind = e.rd; m_din = e.data; m_from_ld = 1'b1;
      end
    end else if (alu_acc && a_rd != 0) begin
      m_wen = 1'b1; m_aind = a_rd; m_din = a_d; m_from_ld = 1'b0;
    end
    if (ld_acc) begin
      e.rd = l_rd; e.data = l_d;
      m_q.push_back(e);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid_WB = 0; alu_rd_WB = '0; alu_data_WB = '0;
    ld_issue_WB = 0; ld_issue_rd_WB = '0;
    ld_valid_WB = 0; ld_rd_WB = '0; ld_data_WB = '0;
    chk_rs1_WB = '0; chk_rs2_WB = '0; chk_rd_WB = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (wen_REGS !== 1'b0) begin miscompares++; $display("FAIL reset_wen got %0b want 0", wen_REGS); end
    vectors++; if (aind_REGS !== '0) begin miscompares++; $display("FAIL reset_aind got %0d want 0", aind_REGS); end
    vectors++; if (din_REGS !== '0) begin miscompares++; $display("FAIL reset_din got %h want 0", din_REGS); end
    vectors++; if (pending_WB !== '0) begin miscompares++; $display("FAIL reset_pending got %h want 0", pending_WB); end
    vectors++; if (err_WB !== 1'b0) begin miscompares++; $display("FAIL reset_err got %0b want 0", err_WB); end
    vectors++; if (alu_ready_WB !== 1'b1 || ld_ready_WB !== 1'b1) begin miscompares++;
      $display("FAIL reset_ready got alu=%0b ld=%0b want 1 1", alu_ready_WB, ld_ready_WB); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    alu_valid_WB = 1; alu_rd_WB = 5; alu_data_WB = 64'h1234;
    #1;
    vectors++; if (alu_ready_WB !== 1'b1) begin miscompares++; $display("FAIL alu_ready got %0b want 1", alu_ready_WB); end
    tick();
    alu_valid_WB = 0;
    vectors++; if (wen_REGS !== 1'b1 || aind_REGS !== 5 || din_REGS !== 64'h1234) begin miscompares++;
      $display("FAIL alu_write got wen=%0b aind=%0d din=%h want 1 5 1234", wen_REGS, aind_REGS, din_REGS); end
    tick();
    vectors++; if (wen_REGS !== 1'b0) begin miscompares++; $display("FAIL alu_wen_pulse got %0b want 0", wen_REGS); end
  endtask

  task automatic test_load_raw();
    ld_issue_WB = 1; ld_issue_rd_WB = 7; chk_rs1_WB = 7;
    tick();
    ld_issue_WB = 0;
    for (int c = 1; c <= 5; c++) begin
      ld_valid_WB = (c == 3); ld_rd_WB = 7; ld_data_WB = 64'hAB;
      #1;
      vectors++; if (stall_WB !== 1'b1) begin miscompares++; $display("FAIL raw_stall cyc %0d got %0b want 1", c, stall_WB); end
      if (c == 5) begin
        vectors++; if (wen_REGS !== 1'b1 || aind_REGS !== 7 || din_REGS !== 64'hAB) begin miscompares++;
          $display("FAIL raw_write got wen=%0b aind=%0d din=%h want 1 7 ab", wen_REGS, aind_REGS, din_REGS); end
      end
      tick();
    end
    ld_valid_WB = 0;
    #1;
    vectors++; if (stall_WB !== 1'b0 || pending_WB[7] !== 1'b0) begin miscompares++;
      $display("FAIL raw_release got stall=%0b pend7=%0b want 0 0", stall_WB, pending_WB[7]); end
    vectors++; if (err_WB !== 1'b0) begin miscompares++; $display("FAIL raw_err got %0b want 0", err_WB); end
    chk_rs1_WB = 0;
  endtask

  task automatic test_priority();
    ld_issue_WB = 1; ld_issue_rd_WB = 10; tick();
    ld_issue_rd_WB = 11; tick();
    ld_issue_WB = 0;
    ld_valid_WB = 1; ld_rd_WB = 10; ld_data_WB = 64'hD0;
    tick();
    ld_rd_WB = 11; ld_data_WB = 64'hD1;
    alu_valid_WB = 1; alu_rd_WB = 3; alu_data_WB = 64'h3333;
    #1;
    vectors++; if (alu_ready_WB !== 1'b0 || ld_ready_WB !== 1'b1) begin miscompares++;
      $display("FAIL prio_c3 got alu_rdy=%0b ld_rdy=%0b want 0 1", alu_ready_WB, ld_ready_WB); end
    tick();
    ld_valid_WB = 0;
    #1;
    vectors++; if (alu_ready_WB !== 1'b0 || wen_REGS !== 1'b1 || aind_REGS !== 10 || din_REGS !== 64'hD0) begin miscompares++;
      $display("FAIL prio_first got alu_rdy=%0b wen=%0b aind=%0d din=%h want 0 1 10 d0", alu_ready_WB, wen_REGS, aind_REGS, din_REGS); end
    tick();
    vectors++; if (alu_ready_WB !== 1'b1 || wen_REGS !== 1'b1 || aind_REGS !== 11 || din_REGS !== 64'hD1) begin miscompares++;
      $display("FAIL prio_second got alu_rdy=%0b wen=%0b aind=%0d din=%h want 1 1 11 d1", alu_ready_WB, wen_REGS, aind_REGS, din_REGS); end
    tick();
    alu_valid_WB = 0;
    vectors++; if (wen_REGS !== 1'b1 || aind_REGS !== 3 || din_REGS !== 64'h3333) begin miscompares++;
      $display("FAIL prio_alu got wen=%0b aind=%0d din=%h want 1 3 3333", wen_REGS, aind_REGS, din_REGS); end
    tick();
    vectors++; if (wen_REGS !== 1'b0 || pending_WB[10] !== 1'b0 || pending_WB[11] !== 1'b0) begin miscompares++;
      $display("FAIL prio_done got wen=%0b pend=%h want 0 and bits 10,11 clear", wen_REGS, pending_WB); end
  endtask

  task automatic test_x0_err();
    alu_valid_WB = 1; alu_rd_WB = 0; alu_data_WB = 64'hFFFF;
    #1;
    vectors++; if (alu_ready_WB !== 1'b1) begin miscompares++; $display("FAIL x0_ready got %0b want 1", alu_ready_WB); end
    tick();
    alu_valid_WB = 0;
    vectors++; if (wen_REGS !== 1'b0 || aind_REGS !== 3 || din_REGS !== 64'h3333) begin miscompares++;
      $display("FAIL x0_hold got wen=%0b aind=%0d din=%h want 0 3 3333", wen_REGS, aind_REGS, din_REGS); end
    ld_valid_WB = 1; ld_rd_WB = 9; ld_data_WB = 64'h99;
    #1;
    vectors++; if (err_WB !== 1'b0) begin miscompares++; $display("FAIL err_before got %0b want 0", err_WB); end
    tick();
    ld_valid_WB = 0;
    vectors++; if (err_WB !== 1'b1) begin miscompares++; $display("FAIL err_set got %0b want 1", err_WB); end
    tick();
    vectors++; if (wen_REGS !== 1'b1 || aind_REGS !== 9 || din_REGS !== 64'h99) begin miscompares++;
      $display("FAIL err_write got wen=%0b aind=%0d din=%h want 1 9 99", wen_REGS, aind_REGS, din_REGS); end
    repeat (3) tick();
    vectors++; if (err_WB !== 1'b1) begin miscompares++; $display("FAIL err_sticky got %0b want 1", err_WB); end
  endtask

  task automatic test_set_clear();
    ld_issue_WB = 1; ld_issue_rd_WB = 4; tick();
    ld_issue_WB = 0;
    ld_valid_WB = 1; ld_rd_WB = 4; ld_data_WB = 64'h44; tick();
    ld_valid_WB = 0; tick();
    vectors++; if (wen_REGS !== 1'b1 || aind_REGS !== 4) begin miscompares++;
      $display("FAIL sc_write got wen=%0b aind=%0d want 1 4", wen_REGS, aind_REGS); end
    ld_issue_WB = 1; ld_issue_rd_WB = 4;
    tick();
    ld_issue_WB = 0;
    vectors++; if (pending_WB[4] !== 1'b1) begin miscompares++; $display("FAIL sc_set_wins got %0b want 1", pending_WB[4]); end
    ld_valid_WB = 1; ld_rd_WB = 4; ld_data_WB = 64'h45; tick();
    ld_valid_WB = 0; tick();
    vectors++; if (wen_REGS !== 1'b1 || aind_REGS !== 4 || din_REGS !== 64'h45) begin miscompares++;
      $display("FAIL sc_second got wen=%0b aind=%0d din=%h want 1 4 45", wen_REGS, aind_REGS, din_REGS); end
    tick();
    vectors++; if (pending_WB[4] !== 1'b0) begin miscompares++; $display("FAIL sc_clear got %0b want 0", pending_WB[4]); end
  endtask

  task automatic test_reset_midflight();
    ld_issue_WB = 1; ld_issue_rd_WB = 12; tick();
    ld_issue_rd_WB = 13; tick();
    ld_issue_WB = 0;
    ld_valid_WB = 1; ld_rd_WB = 12; ld_data_WB = 64'hC12; tick();
    ld_rd_WB = 13; ld_data_WB = 64'hC13; tick();
    ld_valid_WB = 0;
    vectors++; if (wen_REGS !== 1'b1 || aind_REGS !== 12) begin miscompares++;
      $display("FAIL mid_inflight got wen=%0b aind=%0d want 1 12", wen_REGS, aind_REGS); end
    rst_n = 1'b0;
    #1;
    vectors++; if (wen_REGS !== 1'b0 || pending_WB !== '0 || err_WB !== 1'b0) begin miscompares++;
      $display("FAIL mid_async got wen=%0b pend=%h err=%0b want 0 0 0", wen_REGS, pending_WB, err_WB); end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      vectors++; if (wen_REGS !== 1'b0 || pending_WB !== '0) begin miscompares++;
        $display("FAIL mid_after cyc %0d got wen=%0b pend=%h want 0 0", c, wen_REGS, pending_WB); end
    end
  endtask

  task automatic test_random();
    bit              held_alu = 0, held_ld = 0, iss, alu_acc, ld_acc;
    logic [AW-1:0]   h_alu_rd = '0, h_ld_rd = '0, i_rd, r;
    logic [XLEN-1:0] h_alu_d = '0, h_ld_d = '0;
    logic [AW-1:0]   out_q[$];
    int              idx;
    bit              exp_stall;
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!held_alu && $urandom_range(0, 2) == 0) begin
        held_alu = 1;
        h_alu_rd = AW'($urandom_range(0, NREG - 1));
        if (m_pend[h_alu_rd]) h_alu_rd = '0;
        h_alu_d = {$urandom, $urandom};
      end
      iss = 0; i_rd = '0;
      if ($urandom_range(0, 3) == 0) begin
        r = AW'($urandom_range(1, NREG - 1));
        if (!m_pend[r]) begin iss = 1; i_rd = r; end
      end
      if (!held_ld && out_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, out_q.size() - 1);
        h_ld_rd = out_q[idx];
        out_q.delete(idx);
        h_ld_d = {$urandom, $urandom};
        held_ld = 1;
      end
      alu_valid_WB = held_alu; alu_rd_WB = h_alu_rd; alu_data_WB = h_alu_d;
      ld_issue_WB = iss; ld_issue_rd_WB = i_rd;
      ld_valid_WB = held_ld; ld_rd_WB = h_ld_rd; ld_data_WB = h_ld_d;
      chk_rs1_WB = AW'($urandom_range(0, NREG - 1));
      chk_rs2_WB = AW'($urandom_range(0, NREG - 1));
      chk_rd_WB  = AW'($urandom_range(0, NREG - 1));
      #1;
      exp_stall = m_pend[chk_rs1_WB] | m_pend[chk_rs2_WB] | m_pend[chk_rd_WB];
      vectors++; if (alu_ready_WB !== (m_q.size() == 0)) begin miscompares++;
        $display("FAIL rnd_alu_ready cyc %0d got %0b want %0b", cyc, alu_ready_WB, m_q.size() == 0); end
      vectors++; if (ld_ready_WB !== (m_q.size() < LQ_DEPTH)) begin miscompares++;
        $display("FAIL rnd_ld_ready cyc %0d got %0b want %0b", cyc, ld_ready_WB, m_q.size() < LQ_DEPTH); end
      vectors++; if (stall_WB !== exp_stall) begin miscompares++;
        $display("FAIL rnd_stall cyc %0d got %0b want %0b", cyc, stall_WB, exp_stall); end
      vectors++; if (pending_WB !== model_pend_vec()) begin miscompares++;
        $display("FAIL rnd_pending cyc %0d got %h want %h", cyc, pending_WB, model_pend_vec()); end
      vectors++; if (err_WB !== m_err) begin miscompares++;
        $display("FAIL rnd_err cyc %0d got %0b want %0b", cyc, err_WB, m_err); end
      vectors++; if (wen_REGS !== m_wen || aind_REGS !== m_aind || din_REGS !== m_din) begin miscompares++;
        $display("FAIL rnd_write cyc %0d got %0b/%0d/%h want %0b/%0d/%h", cyc, wen_REGS, aind_REGS, din_REGS, m_wen, m_aind, m_din); end
      alu_acc = held_alu && (m_q.size() == 0);
      ld_acc  = held_ld && (m_q.size() < LQ_DEPTH);
      model_edge(held_alu, h_alu_rd, h_alu_d, iss, i_rd, held_ld, h_ld_rd, h_ld_d);
      tick();
      if (alu_acc) held_alu = 0;
      if (ld_acc) held_ld = 0;
      if (iss) out_q.push_back(i_rd);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_alu();
    test_load_raw();
    test_priority();
    test_x0_err();
    test_set_clear();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
